// File: rtl/sec09_queues_rr_merge.sv
// Round-robin merge of p_num_reqs valid/ready streams into one pipe-style output buffer, tagging each message with its source.
// Latency: 1 cycle from input handshake to ostream_val. Throughput is 1 msg/cycle while ostream_rdy stays high.
// Backpressure: a full buffer with ostream_rdy low drops every istream_rdy; a draining buffer accepts a new message in the same cycle.
//
// Ports:
//   clk, reset           clock (posedge) and asynchronous active-low reset
//   istream_val/rdy/msg  per-requester handshake; requester i's message sits at istream_msg[i*W +: W]
//   ostream_val/rdy/msg  merged output stream
//   ostream_src          index of the requester that sent ostream_msg
module sec09_queues_rr_merge #(
    parameter int  p_num_reqs  = 4,
    parameter int  p_msg_nbits = 32,
    localparam int c_src_nbits = $clog2(p_num_reqs)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             istream_val,
    output logic [p_num_reqs-1:0]             istream_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] istream_msg,
    output logic                              ostream_val,
    input  logic                              ostream_rdy,
    output logic [p_msg_nbits-1:0]            ostream_msg,
    output logic [c_src_nbits-1:0]            ostream_src
);

    // One spare bit so that ptr + offset cannot overflow before the modulo fold.
    localparam int                     c_sum_nbits = c_src_nbits + 1;
    localparam logic [c_sum_nbits-1:0] c_num       = c_sum_nbits'(p_num_reqs);
    localparam logic [c_src_nbits-1:0] c_last      = c_src_nbits'(p_num_reqs - 1);

    logic                   full_q, full_d;
    logic [p_msg_nbits-1:0] buf_msg_q, buf_msg_d;
    logic [c_src_nbits-1:0] buf_src_q, buf_src_d;
    logic [c_src_nbits-1:0] ptr_q, ptr_d;

    logic                   can_enq;
    logic                   found;
    logic                   enq;
    logic                   deq;
    logic [c_sum_nbits-1:0] sum;
    logic [c_src_nbits-1:0] grant_idx;
    logic [p_num_reqs-1:0]  grant;

    // Scan requesters starting at ptr and wrapping; the first valid one wins.
    // The fold keeps the index inside 0..p_num_reqs-1 for non-power-of-2 counts.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            sum = {1'b0, ptr_q} + c_sum_nbits'(k);
            if (sum >= c_num) begin
                sum = sum - c_num;
            end
            if (!found && istream_val[sum[c_src_nbits-1:0]]) begin
                found     = 1'b1;
                grant_idx = sum[c_src_nbits-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pipe behaviour: a full buffer still has space when it drains this cycle.
    // Ready is also forced low while reset is held.
    assign can_enq     = (!full_q || ostream_rdy) && reset;
    assign istream_rdy = grant & {p_num_reqs{can_enq}};
    assign enq         = found && can_enq;
    assign deq         = full_q && ostream_rdy;

    always_comb begin
        full_d    = full_q;
        buf_msg_d = buf_msg_q;
        buf_src_d = buf_src_q;
        ptr_d     = ptr_q;
        if (enq) begin
            full_d    = 1'b1;
            buf_msg_d = istream_msg[grant_idx*p_msg_nbits +: p_msg_nbits];
            buf_src_d = grant_idx;
            // Priority moves only on enqueue, so idle and stalled cycles keep it.
            ptr_d     = (grant_idx == c_last) ? '0 : grant_idx + c_src_nbits'(1);
        end else if (deq) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= 1'b0;
            buf_msg_q <= '0;
            buf_src_q <= '0;
            ptr_q     <= '0;
        end else begin
            full_q    <= full_d;
            buf_msg_q <= buf_msg_d;
            buf_src_q <= buf_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign ostream_val = full_q;
    assign ostream_msg = buf_msg_q;
    assign ostream_src = buf_src_q;

endmodule
